// File: rtl/chacha_keystream_xor.sv
// rtl/chacha_keystream_xor.sv - ChaCha feed-forward add and plaintext XOR stream stage.
// Optional macro KS_BYTE_SWAP_EN byte-reverses each keystream word before the XOR.
module chacha_keystream_xor #(
  parameter int NWORDS        = 16,
  parameter bit HOLD_ON_STALL = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    blockready,
  input  logic [3:0][3:0][31:0]   chachamatrixOUT,
  input  logic [3:0][3:0][31:0]   initstate,
  input  logic                    pt_valid,
  output logic                    pt_ready,
  input  logic [31:0]             pt_data,
  output logic                    ct_valid,
  input  logic                    ct_ready,
  output logic [31:0]             ct_data,
  output logic                    block_done,
  output logic                    overrun,
  output logic                    busy
);

  localparam int IDXW = $clog2(NWORDS) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_STREAM, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_rst_q;
  logic                  w_rst_n;
  logic [3:0][3:0][31:0] r_mat;
  logic [31:0]           r_ks [NWORDS];
  logic [31:0]           w_ks_in [NWORDS];
  logic [IDXW-1:0]       r_idx;
  logic                  r_ct_valid;
  logic [31:0]           r_ct_data;
  logic                  r_overrun;
  logic                  w_all_loaded;
  logic                  w_pt_fire;
  logic                  w_ct_accept;

  // Assertion is immediate; release takes effect on the first edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_q <= 1'b0;
    else        r_rst_q <= 1'b1;
  end
  assign w_rst_n = r_rst_q;

  assign w_all_loaded = (r_idx == LAST_IDX);
  assign w_pt_fire    = pt_valid && pt_ready;
  assign w_ct_accept  = r_ct_valid && ct_ready;

  for (genvar g = 0; g < NWORDS; g++) begin : g_ks
    logic [31:0] w_sum;
    assign w_sum = r_mat[g/4][g%4] + initstate[g/4][g%4];
`ifdef KS_BYTE_SWAP_EN
    assign w_ks_in[g] = {w_sum[7:0], w_sum[15:8], w_sum[23:16], w_sum[31:24]};
`else
    assign w_ks_in[g] = w_sum;
`endif
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (blockready) w_next = S_ADD;
      S_ADD:    w_next = S_STREAM;
      S_STREAM: if (w_ct_accept && w_all_loaded) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    block_done = (r_state == S_DONE);
    pt_ready   = (r_state == S_STREAM) && !w_all_loaded && (!r_ct_valid || ct_ready);
  end

  // Keystream storage needs no reset: it is always rewritten in ADD before use.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && blockready) r_mat <= chachamatrixOUT;
    if (r_state == S_ADD)                r_ks  <= w_ks_in;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_idx      <= '0;
      r_ct_valid <= 1'b0;
      r_ct_data  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (blockready && r_state != S_IDLE) r_overrun <= 1'b1;
      if (r_state == S_ADD)  r_idx <= '0;
      else if (w_pt_fire)    r_idx <= r_idx + 1'b1;
      if (w_pt_fire) begin
        r_ct_valid <= 1'b1;
        r_ct_data  <= pt_data ^ r_ks[r_idx[IDXW-2:0]];
      end else if (w_ct_accept) begin
        r_ct_valid <= 1'b0;
        if (!HOLD_ON_STALL) r_ct_data <= '0;
      end
    end
  end

  assign ct_valid = r_ct_valid;
  assign ct_data  = r_ct_data;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// tb/tb_chacha_keystream_xor.sv - scoreboard bench for chacha_keystream_xor.
module tb_chacha_keystream_xor;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  blockready;
  logic [3:0][3:0][31:0] mat;
  logic [3:0][3:0][31:0] init;
  logic                  pt_valid;
  logic                  pt_ready;
  logic [31:0]           pt_data;
  logic                  ct_valid;
  logic                  ct_ready;
  logic [31:0]           ct_data;
  logic                  block_done;
  logic                  overrun;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_q[$];
  logic [31:0] m_ks [16];

  logic [31:0] rfc_init [16] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
    32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
    32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
    32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
  logic [31:0] rfc_out [16] = '{
    32'h837778ab, 32'he238d763, 32'ha67ae21e, 32'h5950bb2f,
    32'hc4f2d0c7, 32'hfc62bb2f, 32'h8fa018fc, 32'h3f5ec7b7,
    32'h335271c2, 32'hf29489f3, 32'heabda8fc, 32'h82e46ebd,
    32'hd19c12b4, 32'hb04e16de, 32'h9e83d0cb, 32'h4e3c50a2};

`ifdef KS_BYTE_SWAP_EN
  localparam logic [31:0] RFC_W0 = 32'h10f1e7e4;
`else
  localparam logic [31:0] RFC_W0 = 32'he4e7f110;
`endif

  chacha_keystream_xor #(.NWORDS(16), .HOLD_ON_STALL(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .blockready      (blockready),
    .chachamatrixOUT (mat),
    .initstate       (init),
    .pt_valid        (pt_valid),
    .pt_ready        (pt_ready),
    .pt_data         (pt_data),
    .ct_valid        (ct_valid),
    .ct_ready        (ct_ready),
    .ct_data         (ct_data),
    .block_done      (block_done),
    .overrun         (overrun),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ks_model(input int k);
    logic [31:0] s;
    s = mat[2'(k / 4)][2'(k % 4)] + init[2'(k / 4)][2'(k % 4)];
`ifdef KS_BYTE_SWAP_EN
    s = {s[7:0], s[15:8], s[23:16], s[31:24]};
`endif
    return s;
  endfunction

  task automatic load_words(input logic [31:0] o [16], input logic [31:0] i [16]);
    for (int k = 0; k < 16; k++) begin
      mat[2'(k / 4)][2'(k % 4)]  = o[k];
      init[2'(k / 4)][2'(k % 4)] = i[k];
    end
  endtask

  task automatic load_random();
    for (int k = 0; k < 16; k++) begin
      mat[2'(k / 4)][2'(k % 4)]  = $urandom;
      init[2'(k / 4)][2'(k % 4)] = $urandom;
    end
  endtask

  task automatic run_block(input int stall_word, input int br_word, input int rst_word,
                           input bit rand_pt, input logic [31:0] pt_fixed,
                           output logic [31:0] w0, output bit aborted);
    int n_push = 0;
    int n_acc = 0;
    int stall_cnt = 0;
    int cyc = 0;
    int first_acc = 0;
    int last_acc = 0;
    bit br_done = 1'b0;
    logic [31:0] exp;
    aborted = 1'b0;
    w0 = '0;
    sb_q.delete();
    for (int k = 0; k < 16; k++) m_ks[k] = ks_model(k);
    @(negedge clk); blockready = 1'b1;
    @(negedge clk); blockready = 1'b0;
    while (n_acc < 16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      blockready = 1'b0;
      if (rst_word >= 0 && n_acc == rst_word) begin
        if (br_word >= 0) check("overrun_set", 32'(overrun), 32'd1);
        rst_n = 1'b0;
        pt_valid = 1'b0;
        #1;
        check("rst_ct_valid", 32'(ct_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pt_ready", 32'(pt_ready), 32'd0);
        check("rst_ct_data", ct_data, 32'd0);
        sb_q.delete();
        aborted = 1'b1;
        return;
      end
      ct_ready = 1'b1;
      if (stall_word >= 0 && n_acc == stall_word && ct_valid && stall_cnt < 5) begin
        ct_ready = 1'b0;
        stall_cnt++;
      end
      if (br_word >= 0 && n_acc == br_word && !br_done) begin
        blockready = 1'b1;
        br_done = 1'b1;
      end
      pt_valid = (n_push < 16);
      pt_data  = rand_pt ? $urandom : pt_fixed;
      #1;
      if (ct_valid && !ct_ready) begin
        check("stall_hold", ct_data, sb_q[0]);
        check("stall_pt_ready", 32'(pt_ready), 32'd0);
      end
      if (n_push == 16) check("pt_ready_after_last", 32'(pt_ready), 32'd0);
      if (ct_valid && ct_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          exp = sb_q.pop_front();
          check($sformatf("ct_w%0d", n_acc), ct_data, exp);
        end
        if (n_acc == 0) begin
          first_acc = cyc;
          w0 = ct_data;
        end
        last_acc = cyc;
        n_acc++;
      end
      if (pt_valid && pt_ready) begin
        sb_q.push_back(pt_data ^ m_ks[4'(n_push)]);
        n_push++;
      end
    end
    pt_valid = 1'b0;
    check("block_words", 32'(n_acc), 32'd16);
    if (stall_word < 0) check("throughput", 32'(last_acc - first_acc), 32'd15);
    @(negedge clk); #1;
    check("done_pulse", 32'(block_done), 32'd1);
    check("done_ct_valid", 32'(ct_valid), 32'd0);
    check("done_pt_ready", 32'(pt_ready), 32'd0);
    @(negedge clk); #1;
    check("done_clear", 32'(block_done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0;
    bit          ab;
    rst_n = 1'b0; blockready = 1'b0; pt_valid = 1'b0; pt_data = '0; ct_ready = 1'b1;
    mat = '0; init = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ct_valid", 32'(ct_valid), 32'd0);
    check("reset_ct_data", ct_data, 32'd0);
    check("reset_pt_ready", 32'(pt_ready), 32'd0);
    check("reset_done", 32'(block_done), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    load_words(rfc_out, rfc_init);
    run_block(-1, -1, -1, 1'b0, 32'h0, w0, ab);
    check("rfc_word0", w0, RFC_W0);

    for (int k = 0; k < 16; k++) begin
      mat[2'(k / 4)][2'(k % 4)]  = 32'h00000001;
      init[2'(k / 4)][2'(k % 4)] = 32'hFFFFFFFF;
    end
    run_block(-1, -1, -1, 1'b0, 32'hA5A5A5A5, w0, ab);
    check("wrap_word0", w0, 32'hA5A5A5A5);

    load_random();
    run_block(3, -1, -1, 1'b1, 32'h0, w0, ab);

    load_random();
    run_block(-1, 7, 10, 1'b1, 32'h0, w0, ab);
    check("aborted", 32'(ab), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("post_rst_ct_valid", 32'(ct_valid), 32'd0);
      check("post_rst_overrun", 32'(overrun), 32'd0);
    end

    load_random();
    run_block(-1, -1, -1, 1'b1, 32'h0, w0, ab);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
